// File: rtl/i281_mc_pkg.sv
// Shared definitions for the i281 multicycle control sequencer.
//   state_t           : sequencer state encoding (also exported on the debug port)
//   OP_*              : opcode nibble values (opcode_byte[7:4])
//   BR_*              : branch-type field values (opcode_byte[1:0])
//   FLAG_*            : bit positions inside flags_reg = {C, O, N, Z}
//   seq_last_state()  : final state of each instruction's sequence
//   op_* predicates   : per-opcode datapath behaviour used by the output decode
package i281_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_INPUT  = 4'h1;
  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [3:0] OP_LOADI  = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SUBI   = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_LOADF  = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_STOREF = 4'hB;
  localparam logic [3:0] OP_SHIFT  = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_BR     = 4'hF;

  localparam logic [1:0] BR_BRE  = 2'd0;
  localparam logic [1:0] BR_BRNE = 2'd1;
  localparam logic [1:0] BR_BRG  = 2'd2;
  localparam logic [1:0] BR_BRGE = 2'd3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_C = 3;

  // Final state of the sequence for a given opcode; the done cycle.
  function automatic state_t seq_last_state(input logic [3:0] opcode);
    case (opcode)
      OP_NOOP:                     return ST_DECODE;
      OP_CMP, OP_JUMP, OP_BR:      return ST_EXEC;
      OP_STORE, OP_STOREF:         return ST_MEM;
      default:                     return ST_WB;
    endcase
  endfunction

  function automatic logic op_is_branch(input logic [3:0] opcode);
    return (opcode == OP_JUMP) || (opcode == OP_BR);
  endfunction

  function automatic logic op_uses_mem(input logic [3:0] opcode);
    return (opcode == OP_INPUT) || (opcode == OP_LOAD) || (opcode == OP_LOADF) ||
           (opcode == OP_STORE) || (opcode == OP_STOREF);
  endfunction

  function automatic logic op_mem_read(input logic [3:0] opcode);
    return (opcode == OP_INPUT) || (opcode == OP_LOAD) || (opcode == OP_LOADF);
  endfunction

  function automatic logic op_writes_flags(input logic [3:0] opcode);
    return ((opcode >= OP_ADD) && (opcode <= OP_SUBI)) ||
           (opcode == OP_SHIFT) || (opcode == OP_CMP);
  endfunction

endpackage

// File: rtl/i281_mc_sequencer_branch_eval.sv
// Branch condition evaluator (purely combinational).
//   flags   : {C, O, N, Z}
//   br_type : branch-type field of the instruction
//   opcode  : opcode nibble
//   taken   : 1 for JUMP, condition result for BR, 0 for everything else
module i281_branch_eval
  import i281_mc_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [1:0] br_type,
  input  logic [3:0] opcode,
  output logic       taken
);

  logic z, n, o;
  logic cond;
  logic unused_carry;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign o = flags[FLAG_O];
  // Carry participates in no branch condition.
  assign unused_carry = flags[FLAG_C];

  // NOTE: every variable written in always_comb gets a default on entry so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BRE:  cond = z;
      BR_BRNE: cond = !z;
      BR_BRG:  cond = !z && (n == o);
      BR_BRGE: cond = (n == o);
      default: cond = 1'b0;
    endcase
  end

  assign taken = (opcode == OP_JUMP) || ((opcode == OP_BR) && cond);

endmodule

// File: rtl/i281_mc_sequencer.sv
// Multicycle control sequencer for the i281 CPU.
// Ports:
//   clock, reset (sync, active-low)
//   run          : free-run level
//   step         : one-instruction pulse, honoured only in IDLE
//   opcode_byte  : {opcode[7:4], rA[3:2], rB/br_type[1:0]} from the opcode stage
//   flags_reg    : {C, O, N, Z}
//   ir_load, pc_inc, pc_load, alu_en, flags_we, mem_rd, mem_wr, reg_we :
//                  per-cycle datapath enables
//   next_instruction_trigger : pulse in the final cycle of every instruction
//   busy, state  : status / debug
//   retired      : completed-instruction counter, wraps
// All outputs are decoded from registered state only (Moore).
module i281_mc_sequencer
  import i281_mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       opcode_byte,
  input  logic [3:0]       flags_reg,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             alu_en,
  output logic             flags_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_we,
  output logic             next_instruction_trigger,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [7:0]       op_q;
  logic             taken_q;
  logic             taken_d;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       opcode;
  logic             done;
  logic             unused_ra;

  assign opcode    = op_q[7:4];
  // Register fields are consumed by the datapath, not the sequencer.
  assign unused_ra = ^op_q[3:2];

  // The final state never coincides with IDLE or FETCH, so equality alone
  // identifies the done cycle.
  assign done = (state_q == seq_last_state(opcode));

  // Flags are evaluated during DECODE against the opcode captured on entry.
  i281_branch_eval u_branch_eval (
    .flags   (flags_reg),
    .br_type (op_q[1:0]),
    .opcode  (opcode),
    .taken   (taken_d)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order across always blocks.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Instruction context and retirement count. The opcode is captured on the
  // FETCH->DECODE edge so DECODE's own outputs (NOOP completion) stay Moore;
  // the branch decision is captured on the DECODE->EXEC edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q      <= '0;
      taken_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state_q == ST_FETCH)  op_q    <= opcode_byte;
      if (state_q == ST_DECODE) taken_q <= taken_d;
      if (done)                 retired_q <= retired_q + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run || step) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = op_uses_mem(opcode) ? ST_MEM : ST_WB;
      ST_MEM:    state_d = ST_WB;
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
    // Instructions always run to completion; run only decides what follows.
    if (done) state_d = run ? ST_FETCH : ST_IDLE;
  end

  // Output decode.
  always_comb begin
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_en   = 1'b0;
    flags_we = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      ST_EXEC: begin
        alu_en   = !op_is_branch(opcode);
        flags_we = op_writes_flags(opcode);
        pc_load  = taken_q;
      end
      ST_MEM: begin
        mem_rd = op_mem_read(opcode);
        mem_wr = !op_mem_read(opcode);
      end
      ST_WB:   reg_we = 1'b1;
      default: ;
    endcase
  end

  assign next_instruction_trigger = done;
  assign busy    = (state_q != ST_IDLE);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_i281_mc_sequencer.sv
// Directed bench for i281_mc_sequencer. Inputs change 1 ns after the rising
// edge; outputs are sampled at that same point, well clear of the edge.
// A second instance with a 2-bit counter shares all inputs so the counter
// wrap can be reached in a handful of instructions.
module tb_i281_mc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b1;
  logic        step  = 1'b0;
  logic [7:0]  opcode_byte = 8'h41;
  logic [3:0]  flags_reg   = 4'b0000;

  logic        ir_load, pc_inc, pc_load, alu_en, flags_we;
  logic        mem_rd, mem_wr, reg_we, trig, busy;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        s_ir_load, s_pc_inc, s_pc_load, s_alu_en, s_flags_we;
  logic        s_mem_rd, s_mem_wr, s_reg_we, s_trig, s_busy;
  logic [2:0]  s_state;
  logic [1:0]  s_retired;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  i281_mc_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .opcode_byte(opcode_byte), .flags_reg(flags_reg),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_en(alu_en),
    .flags_we(flags_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we),
    .next_instruction_trigger(trig), .busy(busy), .state(state),
    .retired(retired)
  );

  i281_mc_sequencer #(.CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .opcode_byte(opcode_byte), .flags_reg(flags_reg),
    .ir_load(s_ir_load), .pc_inc(s_pc_inc), .pc_load(s_pc_load),
    .alu_en(s_alu_en), .flags_we(s_flags_we), .mem_rd(s_mem_rd),
    .mem_wr(s_mem_wr), .reg_we(s_reg_we), .next_instruction_trigger(s_trig),
    .busy(s_busy), .state(s_state), .retired(s_retired)
  );

  // Control vector: {ir_load, pc_inc, pc_load, alu_en, flags_we,
  //                  mem_rd, mem_wr, reg_we, trigger, busy}
  localparam logic [9:0] C_IDLE   = 10'b0000000000;
  localparam logic [9:0] C_FETCH  = 10'b1100000001;
  localparam logic [9:0] C_DEC    = 10'b0000000001;
  localparam logic [9:0] C_DEC_NP = 10'b0000000011;
  localparam logic [9:0] C_EX_ALF = 10'b0001100001;
  localparam logic [9:0] C_EX_AL  = 10'b0001000001;
  localparam logic [9:0] C_EX_CMP = 10'b0001100011;
  localparam logic [9:0] C_EX_BT  = 10'b0010000011;
  localparam logic [9:0] C_EX_BN  = 10'b0000000011;
  localparam logic [9:0] C_MEM_RD = 10'b0000010001;
  localparam logic [9:0] C_MEM_WR = 10'b0000001011;
  localparam logic [9:0] C_WB     = 10'b0000000111;

  function automatic logic [9:0] ctrl_now();
    return {ir_load, pc_inc, pc_load, alu_en, flags_we,
            mem_rd, mem_wr, reg_we, trig, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [2:0] st,
                              input logic [9:0] ctrl);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctrl"},  32'(ctrl_now()), 32'(ctrl));
  endtask

  // One stepped branch-class instruction from IDLE; checks the EXEC cycle.
  task automatic step_exec3(input string tag, input logic [7:0] op,
                            input logic [3:0] fl, input logic [9:0] exp_ex);
    opcode_byte = op;
    flags_reg   = fl;
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_cycle({tag, "_F"}, 3'd1, C_FETCH);
    tick();
    expect_cycle({tag, "_D"}, 3'd2, C_DEC);
    tick();
    expect_cycle({tag, "_E"}, 3'd3, exp_ex);
    tick();
    check({tag, "_idle"}, 32'(state), 32'd0);
  endtask

  initial begin
    // Reset held three cycles with run high.
    repeat (3) tick();
    expect_cycle("rst", 3'd0, C_IDLE);
    check("rst_retired", 32'(retired), 32'd0);

    // ADD from free-run.
    reset = 1'b1;
    tick(); expect_cycle("add1_F", 3'd1, C_FETCH);
    tick(); expect_cycle("add1_D", 3'd2, C_DEC);
    tick(); expect_cycle("add1_E", 3'd3, C_EX_ALF);
    tick(); expect_cycle("add1_W", 3'd5, C_WB);
    tick(); expect_cycle("add2_F", 3'd1, C_FETCH);
    check("add1_retired", 32'(retired), 32'd1);
    run = 1'b0;
    tick(); expect_cycle("add2_D", 3'd2, C_DEC);
    tick(); expect_cycle("add2_E", 3'd3, C_EX_ALF);
    tick(); expect_cycle("add2_W", 3'd5, C_WB);
    tick(); expect_cycle("add2_idle", 3'd0, C_IDLE);
    check("add2_retired", 32'(retired), 32'd2);

    // Single-step LOAD; a step while busy must be ignored.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst2_retired", 32'(retired), 32'd0);
    opcode_byte = 8'h80;
    step = 1'b1;
    tick(); expect_cycle("ld_F", 3'd1, C_FETCH);
    step = 1'b0;
    tick(); expect_cycle("ld_D", 3'd2, C_DEC);
    tick(); expect_cycle("ld_E", 3'd3, C_EX_AL);
    step = 1'b1;
    tick(); expect_cycle("ld_M", 3'd4, C_MEM_RD);
    step = 1'b0;
    tick(); expect_cycle("ld_W", 3'd5, C_WB);
    tick(); expect_cycle("ld_idle", 3'd0, C_IDLE);
    check("ld_retired", 32'(retired), 32'd1);
    tick(); expect_cycle("ld_idle2", 3'd0, C_IDLE);

    // Branches, jump and compare ({C,O,N,Z}).
    step_exec3("brne_z1",  8'hF1, 4'b0001, C_EX_BN);
    step_exec3("brne_z0",  8'hF1, 4'b0000, C_EX_BT);
    step_exec3("brg_t",    8'hF2, 4'b0110, C_EX_BT);
    step_exec3("brg_n",    8'hF2, 4'b0010, C_EX_BN);
    step_exec3("bre_t",    8'hF0, 4'b0001, C_EX_BT);
    step_exec3("brge_n",   8'hF3, 4'b0100, C_EX_BN);
    step_exec3("jump",     8'hE0, 4'b0000, C_EX_BT);
    step_exec3("cmp",      8'hD6, 4'b0000, C_EX_CMP);
    check("br_retired", 32'(retired), 32'd9);

    // STORE with run dropped during MEM.
    opcode_byte = 8'hA0;
    flags_reg   = 4'b0000;
    run = 1'b1;
    tick(); expect_cycle("st_F", 3'd1, C_FETCH);
    tick(); expect_cycle("st_D", 3'd2, C_DEC);
    tick(); expect_cycle("st_E", 3'd3, C_EX_AL);
    tick(); expect_cycle("st_M", 3'd4, C_MEM_WR);
    run = 1'b0;
    tick(); expect_cycle("st_idle", 3'd0, C_IDLE);
    check("st_retired", 32'(retired), 32'd10);

    // Back-to-back NOOPs: the 2-bit counter reaches all-ones then wraps.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    opcode_byte = 8'h00;
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("nop%0d_F", i), 3'd1, C_FETCH);
      check($sformatf("nop%0d_small_cnt", i), 32'(s_retired), 32'(i));
      tick();
      expect_cycle($sformatf("nop%0d_D", i), 3'd2, C_DEC_NP);
      if (i == 3) run = 1'b0;
      tick();
    end
    expect_cycle("nop_idle", 3'd0, C_IDLE);
    check("nop_retired", 32'(retired), 32'd4);
    check("nop_small_wrap", 32'(s_retired), 32'd0);

    // Reset during EXEC of SUB: no write-back follows.
    opcode_byte = 8'h61;
    run = 1'b1;
    tick(); expect_cycle("sub_F", 3'd1, C_FETCH);
    tick(); expect_cycle("sub_D", 3'd2, C_DEC);
    tick(); expect_cycle("sub_E", 3'd3, C_EX_ALF);
    reset = 1'b0;
    tick(); expect_cycle("sub_rst", 3'd0, C_IDLE);
    check("sub_rst_retired", 32'(retired), 32'd0);
    tick(); expect_cycle("sub_rst2", 3'd0, C_IDLE);
    run = 1'b0;
    reset = 1'b1;
    tick(); expect_cycle("sub_after", 3'd0, C_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
